// File: rtl/sram_access_ctrl_pkg.sv
// Shared constants and types for the SRAM access controller.
//   WORD_WIDTH      : pipeline data/address bus width
//   SRAM_DATA_WIDTH : external SRAM DQ width
//   SRAM_ADDR_WIDTH : external SRAM half-word address width
//   state_e         : controller FSM encoding
//   req_t           : operands latched when a request is accepted
package sram_access_ctrl_pkg;

    localparam int unsigned WORD_WIDTH      = 32;
    localparam int unsigned SRAM_DATA_WIDTH = 16;
    localparam int unsigned SRAM_ADDR_WIDTH = 18;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef struct packed {
        logic                  wr;
        logic [WORD_WIDTH-1:0] wdata;
    } req_t;

endpackage

// File: rtl/sram_phase_timer.sv
// Wait-state counter for one half-word SRAM phase.
//   clk, rst     : clock, async active-low reset
//   clear        : restart the count at 0 on the next clock
//   count_next_c : count value for the next clock
//   tc_c         : current count has reached WAIT_CYCLES (last cycle of the phase)
module sram_phase_timer #(
    parameter int unsigned WAIT_CYCLES = 2,
    localparam int unsigned CNT_W      = $clog2(WAIT_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    output logic [CNT_W-1:0] count_next_c,
    output logic             tc_c
);

    logic [CNT_W-1:0] count_q;

    assign tc_c         = (count_q == CNT_W'(WAIT_CYCLES));
    assign count_next_c = clear ? '0 : CNT_W'(count_q + 1'b1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_next_c;
        end
    end

endmodule

// File: rtl/sram_access_ctrl.sv
// Multi-cycle MEM-stage data memory controller for a 16-bit asynchronous SRAM.
// Each 32-bit access is split into a low and a high half-word phase of
// WAIT_CYCLES+1 clocks each; ready stays low to freeze the pipeline meanwhile.
//   clk, rst                 : clock, async active-low reset
//   rd_en, wr_en             : load / store request (store wins if both)
//   address, write_data      : byte address and store data
//   read_data                : last completed load word
//   ready                    : combinational; low = freeze the pipeline
//   sram_addr, sram_dq_out   : SRAM half-word address and write data
//   sram_dq_in               : SRAM read data
//   sram_dq_oe, sram_we_n    : DQ drive enable, active-low write strobe
module sram_access_ctrl
    import sram_access_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned ADDR_BASE   = 1024,
    parameter int unsigned SRAM_ADDR_W = SRAM_ADDR_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rd_en,
    input  logic                       wr_en,
    input  logic [WORD_WIDTH-1:0]      address,
    input  logic [WORD_WIDTH-1:0]      write_data,
    output logic [WORD_WIDTH-1:0]      read_data,
    output logic                       ready,
    output logic [SRAM_ADDR_W-1:0]     sram_addr,
    output logic [SRAM_DATA_WIDTH-1:0] sram_dq_out,
    input  logic [SRAM_DATA_WIDTH-1:0] sram_dq_in,
    output logic                       sram_dq_oe,
    output logic                       sram_we_n
);

    localparam int unsigned CNT_W = $clog2(WAIT_CYCLES + 1);

    state_e                     state_q, state_d;
    req_t                       req_q, req_d;
    logic [SRAM_ADDR_W-2:0]     word_q, word_d;
    logic [SRAM_DATA_WIDTH-1:0] lo_half_q;
    logic [CNT_W-1:0]           cnt_next;
    logic                       tc;
    logic                       clear_c;
    logic                       req_c;
    logic                       in_phase_d;
    logic [SRAM_ADDR_W-1:0]     sram_addr_d;
    logic [SRAM_DATA_WIDTH-1:0] sram_dq_out_d;
    logic                       sram_dq_oe_d;
    logic                       sram_we_n_d;

    assign req_c   = rd_en | wr_en;
    // Counter restarts outside the phases and at the end of each phase.
    assign clear_c = !(state_q == ST_LO || state_q == ST_HI) || tc;

    sram_phase_timer #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_timer (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear_c),
        .count_next_c (cnt_next),
        .tc_c         (tc)
    );

    // Next state, operand latch, and SRAM pins for the coming cycle.
    always_comb begin
        state_d       = state_q;
        req_d         = req_q;
        word_d        = word_q;
        ready         = 1'b0;
        sram_addr_d   = sram_addr;
        sram_dq_out_d = sram_dq_out;
        sram_dq_oe_d  = 1'b0;
        sram_we_n_d   = 1'b1;

        case (state_q)
            ST_IDLE: begin
                ready = !req_c;
                if (req_c) begin
                    state_d     = ST_LO;
                    req_d.wr    = wr_en;
                    req_d.wdata = write_data;
                    // 32-bit offset, word index, upper bits dropped (wraps).
                    word_d      = (SRAM_ADDR_W-1)'((address - WORD_WIDTH'(ADDR_BASE)) >> 2);
                end
            end
            ST_LO:   if (tc) state_d = ST_HI;
            ST_HI:   if (tc) state_d = ST_DONE;
            ST_DONE: begin
                ready   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Pins are registered, so decode them from the state/count we are entering.
        in_phase_d = (state_d == ST_LO) || (state_d == ST_HI);
        if (in_phase_d) begin
            sram_addr_d = {word_d, (state_d == ST_HI)};
            if (req_d.wr) begin
                sram_dq_oe_d  = 1'b1;
                // Strobe released on the last count: address/data hold cycle.
                sram_we_n_d   = (cnt_next == CNT_W'(WAIT_CYCLES));
                sram_dq_out_d = (state_d == ST_HI) ? req_d.wdata[WORD_WIDTH-1:SRAM_DATA_WIDTH]
                                                   : req_d.wdata[SRAM_DATA_WIDTH-1:0];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latched operands, read assembly and SRAM pin registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_q       <= '0;
            word_q      <= '0;
            lo_half_q   <= '0;
            read_data   <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
        end else begin
            req_q       <= req_d;
            word_q      <= word_d;
            sram_addr   <= sram_addr_d;
            sram_dq_out <= sram_dq_out_d;
            sram_dq_oe  <= sram_dq_oe_d;
            sram_we_n   <= sram_we_n_d;
            // Sample the SRAM at the end of each read phase.
            if (!req_q.wr && tc) begin
                if (state_q == ST_LO) lo_half_q <= sram_dq_in;
                if (state_q == ST_HI) read_data <= {sram_dq_in, lo_half_q};
            end
        end
    end

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Directed self-checking bench for sram_access_ctrl with a behavioural SRAM
// that commits a write on the rising edge of we_n while the controller drives DQ.
module tb_sram_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic [15:0] sram_dq_in;
    logic        sram_dq_oe;
    logic        sram_we_n;

    int n_checks = 0;
    int n_pass   = 0;

    localparam int MAX_CYCLES = 20;

    sram_access_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .rd_en       (rd_en),
        .wr_en       (wr_en),
        .address     (address),
        .write_data  (write_data),
        .read_data   (read_data),
        .ready       (ready),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_in  (sram_dq_in),
        .sram_dq_oe  (sram_dq_oe),
        .sram_we_n   (sram_we_n)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM, 16 half-words.
    logic [15:0] mem [16];
    logic        prev_we_n = 1'b1;

    assign sram_dq_in = sram_dq_oe ? 16'h0000 : mem[sram_addr[3:0]];

    always @(negedge clk) begin
        if (sram_dq_oe && sram_we_n && !prev_we_n) mem[sram_addr[3:0]] = sram_dq_out;
        prev_we_n = sram_we_n;
    end

    // Runs one access starting at a negedge in IDLE; scrambles the inputs after
    // the request is accepted; returns at the negedge of the following IDLE cycle.
    task automatic run_access(input logic wr, input logic rd, input logic [31:0] a,
                              input logic [31:0] d, output int n_low,
                              output int we_lo0, output int we_lo1,
                              output logic [31:0] rdata);
        n_low = 0; we_lo0 = 0; we_lo1 = 0; rdata = 32'h0;
        wr_en = wr; rd_en = rd; address = a; write_data = d;
        for (int i = 0; i < MAX_CYCLES; i++) begin
            #1;
            if (ready) begin
                rdata = read_data;
                break;
            end
            n_low++;
            if (!sram_we_n) begin
                if (sram_addr[0]) we_lo1++;
                else              we_lo0++;
            end
            @(posedge clk); #1;
            if (i == 0) begin
                wr_en = 1'b0; rd_en = 1'b0;
                address = 32'hFFFF_FFF0; write_data = 32'h0BAD_0BAD;
            end
            @(negedge clk);
        end
        wr_en = 1'b0; rd_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b0; rd_en = 1'b0; wr_en = 1'b0; address = 32'h0; write_data = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if (ready !== 1'b1) $display("FAIL reset_ready got %b want 1", ready); else n_pass++;
        n_checks++; if (sram_we_n !== 1'b1) $display("FAIL reset_we_n got %b want 1", sram_we_n); else n_pass++;
        n_checks++; if (sram_dq_oe !== 1'b0) $display("FAIL reset_oe got %b want 0", sram_dq_oe); else n_pass++;
        n_checks++; if (sram_addr !== 18'h0) $display("FAIL reset_addr got %h want 0", sram_addr); else n_pass++;
        n_checks++; if (sram_dq_out !== 16'h0) $display("FAIL reset_dq_out got %h want 0", sram_dq_out); else n_pass++;
        n_checks++; if (read_data !== 32'h0) $display("FAIL reset_read_data got %h want 0", read_data); else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        n_checks++; if (ready !== 1'b1) $display("FAIL idle_ready got %b want 1", ready); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_write_basic;
        int n_low, w0, w1;
        logic [31:0] rd;
        run_access(1'b1, 1'b0, 32'd1024, 32'hDEAD_BEEF, n_low, w0, w1, rd);
        n_checks++; if (n_low !== 7) $display("FAIL wr_low_cycles got %0d want 7", n_low); else n_pass++;
        n_checks++; if (w0 !== 2) $display("FAIL wr_we_lo_half got %0d want 2", w0); else n_pass++;
        n_checks++; if (w1 !== 2) $display("FAIL wr_we_hi_half got %0d want 2", w1); else n_pass++;
        n_checks++; if (mem[0] !== 16'hBEEF) $display("FAIL wr_mem0 got %h want beef", mem[0]); else n_pass++;
        n_checks++; if (mem[1] !== 16'hDEAD) $display("FAIL wr_mem1 got %h want dead", mem[1]); else n_pass++;
        n_checks++; if (rd !== 32'h0) $display("FAIL wr_read_data got %h want 0", rd); else n_pass++;
        n_checks++; if (mem[2] !== 16'h2222) $display("FAIL wr_mem2_untouched got %h want 2222", mem[2]); else n_pass++;
    endtask

    task automatic test_read_basic;
        int n_low, w0, w1;
        logic [31:0] rd;
        run_access(1'b0, 1'b1, 32'd1024, 32'h0, n_low, w0, w1, rd);
        n_checks++; if (n_low !== 7) $display("FAIL rd_low_cycles got %0d want 7", n_low); else n_pass++;
        n_checks++; if (rd !== 32'hDEAD_BEEF) $display("FAIL rd_data got %h want deadbeef", rd); else n_pass++;
        n_checks++; if (w0 + w1 !== 0) $display("FAIL rd_we_strobes got %0d want 0", w0 + w1); else n_pass++;
    endtask

    task automatic test_back_to_back;
        int n_low, w0, w1;
        logic [31:0] rd;
        run_access(1'b1, 1'b0, 32'd1028, 32'h1234_5678, n_low, w0, w1, rd);
        n_checks++; if (mem[2] !== 16'h5678) $display("FAIL b2b_mem2 got %h want 5678", mem[2]); else n_pass++;
        n_checks++; if (mem[3] !== 16'h1234) $display("FAIL b2b_mem3 got %h want 1234", mem[3]); else n_pass++;
        run_access(1'b0, 1'b1, 32'd1028, 32'h0, n_low, w0, w1, rd);
        n_checks++; if (n_low !== 7) $display("FAIL b2b_rd1_low got %0d want 7", n_low); else n_pass++;
        n_checks++; if (rd !== 32'h1234_5678) $display("FAIL b2b_rd1_data got %h want 12345678", rd); else n_pass++;
        run_access(1'b0, 1'b1, 32'd1024, 32'h0, n_low, w0, w1, rd);
        n_checks++; if (n_low !== 7) $display("FAIL b2b_rd2_low got %0d want 7", n_low); else n_pass++;
        n_checks++; if (rd !== 32'hDEAD_BEEF) $display("FAIL b2b_rd2_data got %h want deadbeef", rd); else n_pass++;
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (read_data !== 32'hDEAD_BEEF) $display("FAIL b2b_hold got %h want deadbeef", read_data); else n_pass++;
    endtask

    task automatic test_rd_wr_both;
        int n_low, w0, w1;
        logic [31:0] rd;
        run_access(1'b1, 1'b1, 32'd1032, 32'hCAFE_F00D, n_low, w0, w1, rd);
        n_checks++; if (n_low !== 7) $display("FAIL both_low got %0d want 7", n_low); else n_pass++;
        n_checks++; if (mem[4] !== 16'hF00D) $display("FAIL both_mem4 got %h want f00d", mem[4]); else n_pass++;
        n_checks++; if (mem[5] !== 16'hCAFE) $display("FAIL both_mem5 got %h want cafe", mem[5]); else n_pass++;
        n_checks++; if (rd !== 32'hDEAD_BEEF) $display("FAIL both_read_data got %h want deadbeef", rd); else n_pass++;
    endtask

    task automatic test_reset_mid_access;
        int n_low, w0, w1;
        logic [31:0] rd;
        wr_en = 1'b1; address = 32'd1036; write_data = 32'hAAAA_5555;
        @(negedge clk);
        wr_en = 1'b0; address = 32'h0; write_data = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if (sram_addr !== 18'd7) $display("FAIL mid_hi_addr got %0d want 7", sram_addr); else n_pass++;
        n_checks++; if (sram_we_n !== 1'b0) $display("FAIL mid_hi_we_n got %b want 0", sram_we_n); else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++; if (ready !== 1'b1) $display("FAIL mid_rst_ready got %b want 1", ready); else n_pass++;
        n_checks++; if (sram_we_n !== 1'b1) $display("FAIL mid_rst_we_n got %b want 1", sram_we_n); else n_pass++;
        n_checks++; if (sram_dq_oe !== 1'b0) $display("FAIL mid_rst_oe got %b want 0", sram_dq_oe); else n_pass++;
        n_checks++; if (sram_addr !== 18'h0) $display("FAIL mid_rst_addr got %h want 0", sram_addr); else n_pass++;
        n_checks++; if (read_data !== 32'h0) $display("FAIL mid_rst_read_data got %h want 0", read_data); else n_pass++;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (mem[6] !== 16'h5555) $display("FAIL mid_mem6 got %h want 5555", mem[6]); else n_pass++;
        n_checks++; if (mem[7] !== 16'h7777) $display("FAIL mid_mem7 got %h want 7777", mem[7]); else n_pass++;
        run_access(1'b0, 1'b1, 32'd1036, 32'h0, n_low, w0, w1, rd);
        n_checks++; if (rd !== 32'h7777_5555) $display("FAIL post_rst_rd1036 got %h want 77775555", rd); else n_pass++;
        run_access(1'b0, 1'b1, 32'd1028, 32'h0, n_low, w0, w1, rd);
        n_checks++; if (n_low !== 7) $display("FAIL post_rst_low got %0d want 7", n_low); else n_pass++;
        n_checks++; if (rd !== 32'h1234_5678) $display("FAIL post_rst_rd1028 got %h want 12345678", rd); else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 16'(i) * 16'h1111;
        test_reset();
        test_write_basic();
        test_read_basic();
        test_back_to_back();
        test_rd_wr_both();
        test_reset_mid_access();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout passed=%0d total=%0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule

// File: doc/sram_access_ctrl.md
Name: sram_access_ctrl

Overview:
- Multi-cycle controller between the MEM stage's load/store request and an external 16-bit asynchronous SRAM.
- Splits each 32-bit word access into two half-word SRAM cycles (low half, then high half), with programmable wait states per half.
- Drives ready low to freeze the pipeline until the access completes.
- Replaces the single-cycle data memory behind the MEM stage; the freeze network consumes ready.

Parameters:
- WAIT_CYCLES, 2, SRAM wait cycles per half-word phase (≥1); each phase lasts WAIT_CYCLES+1 clocks.
- ADDR_BASE, 1024, byte address mapped to SRAM word 0.
- SRAM_ADDR_W, 18, SRAM half-word address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- rd_en  in  1  load request from the MEM stage.
- wr_en  in  1  store request from the MEM stage.
- address  in  32  byte address (ALU result).
- write_data  in  32  store data (Rm value).
- read_data  out  32  last completed load word.
- ready  out  1  high = no access pending or access completing this cycle; low = freeze the pipeline.
- sram_addr  out  SRAM_ADDR_W  half-word address.
- sram_dq_out  out  16  write data to SRAM.
- sram_dq_in  in  16  read data from SRAM.
- sram_dq_oe  out  1  1 = controller drives the DQ bus.
- sram_we_n  out  1  active-low SRAM write strobe.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, named rst.
- Reset values: state=IDLE, read_data=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_we_n=1, wait counter=0.
- ready in reset is combinational from IDLE and is 1 when no request is present.
- FSM states: IDLE, LO, HI, DONE.
  - IDLE: if rd_en|wr_en, latch op (write if wr_en, else read), address and write_data, then go to LO. Otherwise stay.
  - LO: run WAIT_CYCLES+1 clocks (counter 0..WAIT_CYCLES), then go to HI with the counter cleared.
  - HI: same duration as LO, then go to DONE.
  - DONE: one clock, then go to IDLE.
- ready = (IDLE && !(rd_en|wr_en)) || DONE. This is combinational on the current state and request.
- Latency: a request first seen in IDLE gives ready=0 for 1+2*(WAIT_CYCLES+1) cycles and ready=1 in the DONE cycle. With the default parameters: 7 low cycles, then 1 high cycle.
- Address mapping:
  - word = (address − ADDR_BASE) >> 2, computed in 32-bit arithmetic.
  - sram_addr = {word[SRAM_ADDR_W-2:0], 0} in LO and {word[SRAM_ADDR_W-2:0], 1} in HI.
  - Bits above SRAM_ADDR_W-2 are dropped (wrap-around). Addresses below ADDR_BASE wrap with no error signal.
  - address[1:0] is ignored (word accesses only).
- Write phases:
  - sram_dq_oe=1 throughout LO and HI.
  - sram_dq_out = write_data[15:0] in LO, write_data[31:16] in HI.
  - sram_we_n=0 for counter 0..WAIT_CYCLES-1 and 1 on the final counter cycle, giving a data/address hold cycle.
- Read phases:
  - sram_dq_oe=0 and sram_we_n=1.
  - Capture sram_dq_in into an internal low-half register on the final LO cycle.
  - On the final HI cycle, load read_data = {sram_dq_in, low-half register}.
  - read_data is valid from the DONE cycle onward and holds until the next read completes. Writes never change read_data.
- Mid-access requests: latched operands are used; changes to rd_en, wr_en, address or write_data after IDLE are ignored until the next IDLE.
- rd_en and wr_en both high: performed as a write.
- Back-to-back accesses: after DONE, one IDLE cycle (ready=0 if a request is present) always precedes the next LO.
- Reset mid-access: immediate return to reset values. The SRAM transaction is abandoned and a partial write may leave only the low half written. read_data is cleared.
- Outside LO/HI: sram_addr holds its last value, sram_dq_oe=0, sram_we_n=1.

Decomposition:
- Add to constants.h: SRAM_DATA_WIDTH (16), SRAM_ADDR_WIDTH (18), and the FSM state encodings (2-bit: IDLE=0, LO=1, HI=2, DONE=3). Reuse WORD_WIDTH for 32-bit buses.
- One natural sub-module: sram_phase_timer. It is a wait counter with clear and a terminal-count output (count==WAIT_CYCLES), parameterised by WAIT_CYCLES, and is used for both LO and HI.

Test Plan:
- Reset with no request -> all outputs at reset values; ready=1; sram_we_n=1; sram_dq_oe=0.
- Write 0xDEADBEEF at address 1024 (defaults) -> sram_addr 0 gets 0xBEEF, sram_addr 1 gets 0xDEAD; sram_we_n low 2 cycles per half; ready low 7 cycles, high on the 8th.
- Read address 1024 after that write (behavioural SRAM model) -> read_data=0xDEADBEEF in the DONE cycle; ready pattern as above.
- Write 0x12345678 at 1028, then read 1028 and 1024 back-to-back -> sram_addr 2/3 written 0x5678/0x1234; reads return 0x12345678 then 0xDEADBEEF, each with its own 7-low/1-high ready pattern.
- rd_en=wr_en=1, address 1032, data 0xCAFEF00D -> write performed at sram_addr 4/5; read_data unchanged.
- Assert rst during HI of a write of 0xAAAA5555 at 1036 -> outputs return to reset values immediately; sram_addr 6 holds 0x5555 and sram_addr 7 is unchanged; next request is handled normally.
